// File: rtl/wide_shift_pipe.sv
// Pipelined widening shifter: DATA_W operand -> 2*DATA_W result (SLL/SRL/SRA/ROL), valid/ready per stage.
// Define SHIFT_STICKY_EN to add out_sticky (OR of bits shifted out by right shifts).
module wide_shift_pipe #(
    parameter int DATA_W = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         in_data,
    input  logic [$clog2(DATA_W)+1:0] in_shamt,
    input  logic [1:0]                in_op,
    input  logic [TAG_W-1:0]          in_tag,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [2*DATA_W-1:0]       out_data,
    output logic [TAG_W-1:0]          out_tag
`ifdef SHIFT_STICKY_EN
    ,
    output logic                      out_sticky
`endif
);

    localparam int W  = DATA_W;
    localparam int X  = 2 * DATA_W;
    localparam int LW = $clog2(DATA_W);
    localparam int LX = LW + 1;
    localparam int SW = LW + 2;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROL = 2'b11;

    // Binary shift step k (shamt bit k set); step LX is the "s >= X" saturation step.
    function automatic logic [X-1:0] shift_step(input logic [X-1:0] d, input logic [1:0] op,
                                                input int k);
        logic [W-1:0]        lo;
        logic signed [X-1:0] sd;
        int                  amt;
        amt        = 1 << k;
        lo         = d[W-1:0];
        sd         = d;
        shift_step = d;
        if (k == LX) begin
            case (op)
                OP_SLL, OP_SRL: shift_step = '0;
                OP_SRA:         shift_step = {X{d[X-1]}};
                OP_ROL:         shift_step = d;
            endcase
        end else begin
            case (op)
                OP_SLL: shift_step = d << amt;
                OP_SRL: shift_step = d >> amt;
                OP_SRA: shift_step = sd >>> amt;
                OP_ROL: if (k < LW) shift_step = {{W{1'b0}}, (lo << amt) | (lo >> (W - amt))};
            endcase
        end
    endfunction

    function automatic int step_lo(input int stg);
        return (stg * SW) / STAGES;
    endfunction

`ifdef SHIFT_STICKY_EN
    function automatic logic lost_bits(input logic [X-1:0] d, input logic [1:0] op, input int k);
        logic [X-1:0] mask;
        mask      = ~({X{1'b1}} << (1 << k));
        lost_bits = 1'b0;
        if (op == OP_SRL || op == OP_SRA)
            lost_bits = (k == LX) ? |d : |(d & mask);
    endfunction
`endif

    logic [STAGES-1:0]              vld_q, vld_d, rdy;
    logic [STAGES:0]                vld_pipe;
    logic [STAGES-1:0][X-1:0]       data_q, data_d;
    logic [STAGES:0][X-1:0]         data_pipe;
    logic [STAGES-1:0][TAG_W-1:0]   tag_q, tag_d;
    logic [STAGES:0][TAG_W-1:0]     tag_pipe;
    logic [STAGES-1:0][1:0]         op_pipe;
    logic [STAGES-1:0][SW-1:0]      shamt_pipe;
    logic [X-1:0]                   fmt;
`ifdef SHIFT_STICKY_EN
    logic [STAGES-1:0]              sticky_q, sticky_d;
    logic [STAGES:0]                sticky_pipe;
    assign sticky_pipe = {sticky_q, 1'b0};
    assign out_sticky  = sticky_pipe[STAGES];
`endif

    // Right shifts start from {a, 0}; left shift and rotate from {0, a}.
    assign fmt       = (in_op == OP_SRL || in_op == OP_SRA) ? {in_data, {W{1'b0}}}
                                                            : {{W{1'b0}}, in_data};
    assign vld_pipe  = {vld_q, in_valid};
    assign data_pipe = {data_q, fmt};
    assign tag_pipe  = {tag_q, in_tag};

    always_comb begin : ready_chain
        logic r;
        r   = out_ready;
        rdy = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            r      = !vld_q[i] || r;
            rdy[i] = r;
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = vld_pipe[STAGES];
    assign out_data  = data_pipe[STAGES];
    assign out_tag   = tag_pipe[STAGES];

    always_comb begin : stage_logic
        logic [X-1:0] d;
`ifdef SHIFT_STICKY_EN
        logic         st;
        st       = 1'b0;
        sticky_d = sticky_q;
`endif
        d      = '0;
        vld_d  = vld_q;
        data_d = data_q;
        tag_d  = tag_q;
        for (int i = 0; i < STAGES; i++) begin
            d = data_pipe[i];
`ifdef SHIFT_STICKY_EN
            st = sticky_pipe[i];
`endif
            for (int k = 0; k < SW; k++) begin
                if (k >= step_lo(i) && k < step_lo(i + 1) && shamt_pipe[i][k]) begin
`ifdef SHIFT_STICKY_EN
                    st = st | lost_bits(d, op_pipe[i], k);
`endif
                    d = shift_step(d, op_pipe[i], k);
                end
            end
            if (rdy[i]) vld_d[i] = vld_pipe[i];
            if (rdy[i] && vld_pipe[i]) begin
                data_d[i] = d;
                tag_d[i]  = tag_pipe[i];
`ifdef SHIFT_STICKY_EN
                sticky_d[i] = st;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q    <= '0;
            data_q   <= '0;
            tag_q    <= '0;
`ifdef SHIFT_STICKY_EN
            sticky_q <= '0;
`endif
        end else begin
            vld_q    <= vld_d;
            data_q   <= data_d;
            tag_q    <= tag_d;
`ifdef SHIFT_STICKY_EN
            sticky_q <= sticky_d;
`endif
        end
    end

    // The last stage needs no op/shamt: all steps are done by then.
    if (STAGES > 1) begin : g_ctl
        logic [STAGES-2:0][1:0]    op_q, op_d;
        logic [STAGES-2:0][SW-1:0] shamt_q, shamt_d;

        always_comb begin
            op_d    = op_q;
            shamt_d = shamt_q;
            for (int i = 0; i < STAGES - 1; i++) begin
                if (rdy[i] && vld_pipe[i]) begin
                    op_d[i]    = op_pipe[i];
                    shamt_d[i] = shamt_pipe[i];
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                op_q    <= '0;
                shamt_q <= '0;
            end else begin
                op_q    <= op_d;
                shamt_q <= shamt_d;
            end
        end

        assign op_pipe    = {op_q, in_op};
        assign shamt_pipe = {shamt_q, in_shamt};
    end else begin : g_noctl
        assign op_pipe    = in_op;
        assign shamt_pipe = in_shamt;
    end

endmodule

// File: tb/tb_wide_shift_pipe.sv
// Bench for wide_shift_pipe: directed vectors, backpressure, mid-flight reset, random ops vs a queue model.
module tb_wide_shift_pipe;
    localparam int W      = 32;
    localparam int STAGES = 2;
    localparam int TAG_W  = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [W-1:0]      in_data = '0;
    logic [6:0]        in_shamt = '0;
    logic [1:0]        in_op = '0;
    logic [TAG_W-1:0]  in_tag = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [2*W-1:0]    out_data;
    logic [TAG_W-1:0]  out_tag;
`ifdef SHIFT_STICKY_EN
    logic              out_sticky;
`endif

    wide_shift_pipe #(.DATA_W(W), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_shamt(in_shamt), .in_op(in_op), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag)
`ifdef SHIFT_STICKY_EN
        , .out_sticky(out_sticky)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0]      d;
        logic [TAG_W-1:0] t;
        logic             s;
    } exp_t;

    exp_t             q[$];
    logic [TAG_W-1:0] dq[$];
    int               nvec = 0;
    int               nerr = 0;
    logic             rdy_seen;

    // Reference model: the shift rules written as plain wide arithmetic.
    function automatic logic [63:0] ref_data(input logic [31:0] a, input logic [6:0] s,
                                             input logic [1:0] op);
        logic [63:0] up;
        int          r;
        up = {a, 32'h0};
        r  = int'(s) % 32;
        case (op)
            2'b00:   return {32'h0, a} << s;
            2'b01:   return up >> s;
            2'b10:   return $signed(up) >>> s;
            default: return {32'h0, (a << r) | (a >> (32 - r))};
        endcase
    endfunction

`ifdef SHIFT_STICKY_EN
    function automatic logic ref_sticky(input logic [31:0] a, input logic [6:0] s,
                                        input logic [1:0] op);
        logic [127:0] ext;
        logic [63:0]  low;
        ext = {a, 96'h0} >> s;
        low = ext[63:0];
        if (op == 2'b00 || op == 2'b11) return 1'b0;
        if (s >= 7'd64) return |a;
        return |low;
    endfunction
`endif

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    // One clock: check outputs against the model at negedge, then update the model at posedge.
    task automatic cyc(output bit acc);
        bit               drn;
        exp_t             e;
        logic [TAG_W-1:0] tg;
        @(negedge clk);
        rdy_seen = in_ready;
        chk("in_ready", 64'(in_ready), 64'((q.size() < STAGES) || out_ready));
        if (q.size() == 0) begin
            chk("out_idle", 64'(out_valid), 64'd0);
        end else if (out_valid) begin
            chk("out_data", out_data, q[0].d);
            chk("out_tag", 64'(out_tag), 64'(q[0].t));
`ifdef SHIFT_STICKY_EN
            chk("out_sticky", 64'(out_sticky), 64'(q[0].s));
`endif
        end
        acc = in_valid && in_ready;
        drn = out_valid && out_ready;
        tg  = out_tag;
        e.d = ref_data(in_data, in_shamt, in_op);
        e.t = in_tag;
`ifdef SHIFT_STICKY_EN
        e.s = ref_sticky(in_data, in_shamt, in_op);
`else
        e.s = 1'b0;
`endif
        @(posedge clk);
        if (drn) begin
            dq.push_back(tg);
            if (q.size() > 0) void'(q.pop_front());
        end
        if (acc) q.push_back(e);
        #1;
    endtask

    // Single op into an empty pipe: check latency, then the spec's constant result.
    task automatic run_dir(input string name, input logic [31:0] a, input logic [6:0] s,
                           input logic [1:0] op, input logic [TAG_W-1:0] tag,
                           input logic [63:0] exp, input logic exp_st);
        bit acc;
        in_valid = 1'b1; in_data = a; in_shamt = s; in_op = op; in_tag = tag;
        out_ready = 1'b1;
        cyc(acc);
        in_valid = 1'b0;
        chk("dir_accept", 64'(acc), 64'd1);
        for (int c = 1; c < STAGES; c++) begin
            chk("lat_early", 64'(out_valid), 64'd0);
            cyc(acc);
        end
        chk("lat_valid", 64'(out_valid), 64'd1);
        chk(name, out_data, exp);
        chk("dir_tag", 64'(out_tag), 64'(tag));
`ifdef SHIFT_STICKY_EN
        chk("dir_sticky", 64'(out_sticky), 64'(exp_st));
`else
        if (exp_st === 1'bx) chk("dir_sticky_x", 64'(exp_st), 64'd0);
`endif
        cyc(acc);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        bit saw0;
        int idx;

        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_out_tag", 64'(out_tag), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        run_dir("sll_31",    32'h8000_0001, 7'd31,  2'b00, 4'h3, 64'h4000_0000_8000_0000, 1'b0);
        run_dir("sra_4",     32'h8000_0000, 7'd4,   2'b10, 4'h5, 64'hF800_0000_0000_0000, 1'b0);
        run_dir("srl_4",     32'h8000_0000, 7'd4,   2'b01, 4'h6, 64'h0800_0000_0000_0000, 1'b0);
        run_dir("sll_63",    32'h0000_0001, 7'd63,  2'b00, 4'h7, 64'h8000_0000_0000_0000, 1'b0);
        run_dir("sll_64",    32'hFFFF_FFFF, 7'd64,  2'b00, 4'h8, 64'h0,                   1'b0);
        run_dir("sra_100",   32'h8000_0000, 7'd100, 2'b10, 4'h9, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        run_dir("sra_100p",  32'h7FFF_FFFF, 7'd100, 2'b10, 4'hA, 64'h0,                   1'b1);
        run_dir("srl_64",    32'hFFFF_FFFF, 7'd64,  2'b01, 4'hB, 64'h0,                   1'b1);
        run_dir("rol_36",    32'h1234_5678, 7'd36,  2'b11, 4'hC, 64'h0000_0000_2345_6781, 1'b0);
        run_dir("rol_0",     32'hDEAD_BEEF, 7'd0,   2'b11, 4'hD, 64'h0000_0000_DEAD_BEEF, 1'b0);
        run_dir("srl_35",    32'h0000_000F, 7'd35,  2'b01, 4'hE, 64'h1,                   1'b1);

        // Backpressure: six ops, tags 0..5, consumer stalled in cycles 3..7.
        dq.delete();
        idx  = 0;
        saw0 = 1'b0;
        for (int c = 0; c < 20; c++) begin
            out_ready = !(c >= 3 && c <= 7);
            in_valid  = (idx < 6);
            in_data   = $urandom;
            in_shamt  = 7'($urandom);
            in_op     = 2'($urandom);
            in_tag    = 4'(idx);
            cyc(acc);
            if (in_valid && !rdy_seen) saw0 = 1'b1;
            if (acc) idx++;
        end
        in_valid = 1'b0;
        chk("bp_accepted", 64'(idx), 64'd6);
        chk("bp_ready_drop", 64'(saw0), 64'd1);
        chk("bp_count", 64'(dq.size()), 64'd6);
        for (int i = 0; i < dq.size(); i++) chk("bp_order", 64'(dq[i]), 64'(i));

        // Random traffic with random stalls; shamt biased toward the range edges.
        for (int n = 0; n < 400; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_data   = $urandom;
            case ($urandom_range(0, 5))
                0:       in_shamt = 7'd0;
                1:       in_shamt = 7'd31 + 7'($urandom_range(0, 2));
                2:       in_shamt = 7'd63 + 7'($urandom_range(0, 2));
                3:       in_shamt = 7'd127;
                default: in_shamt = 7'($urandom);
            endcase
            if ($urandom_range(0, 3) == 0) in_data[31] = 1'b1;
            in_op  = 2'($urandom);
            in_tag = 4'($urandom);
            cyc(acc);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 20 && q.size() > 0; c++) cyc(acc);
        chk("drain_empty", 64'(q.size()), 64'd0);
        repeat (3) cyc(acc);

        // Reset with two ops in flight.
        in_valid = 1'b1; in_data = 32'h1; in_shamt = 7'd1; in_op = 2'b00; in_tag = 4'h7;
        cyc(acc);
        in_tag = 4'h8;
        cyc(acc);
        in_valid = 1'b0;
        chk("mf_valid_before", 64'(out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mf_out_valid", 64'(out_valid), 64'd0);
        chk("mf_out_data", out_data, 64'd0);
        chk("mf_out_tag", 64'(out_tag), 64'd0);
`ifdef SHIFT_STICKY_EN
        chk("mf_out_sticky", 64'(out_sticky), 64'd0);
`endif
        q.delete();
        rst_n = 1'b1;
        repeat (4) cyc(acc);
        run_dir("post_rst", 32'hA5A5_0001, 7'd8, 2'b00, 4'h2, 64'h0000_00A5_A500_0100, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/wide_shift_pipe.md
Name: wide_shift_pipe

Overview:
- Pipelined, parametrised widening shifter; successor to the single-mode 32-to-64 combinational left-shift expander.
- Takes a DATA_W operand and produces a 2*DATA_W result.
- Supports logical left, logical right, arithmetic right and rotate modes.
- Valid/ready handshake, tag passthrough, configurable pipeline depth.
- Sits between the execute-stage operand muxes and the multiply/normalise datapath.

Parameters:
- DATA_W, 32: operand width; power of two, >= 8.
- STAGES, 2: number of register stages, 1..3. Also the latency in cycles.
- TAG_W, 4: width of the sideband tag carried alongside each operation.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input operation valid
- in_ready  out  1  input accepted when in_valid && in_ready
- in_data  in  DATA_W  operand A
- in_shamt  in  $clog2(DATA_W)+2  shift amount; 7 bits when DATA_W=32
- in_op  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROL
- in_tag  in  TAG_W  sideband tag, returned unchanged with the result
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid && out_ready
- out_data  out  2*DATA_W  result
- out_tag  out  TAG_W  tag of the result
- out_sticky  out  1  only present with SHIFT_STICKY_EN

Behaviour:
- Notation: W=DATA_W, X=2W, s=in_shamt (unsigned), a=in_data.
- SLL: out = ({W zeros, a} << s) truncated to X bits. If s >= X, out = 0.
- SRL: out = {a, W zeros} >> s. If s >= X, out = 0.
- SRA: out = {a, W zeros} >>> s, filling with a[W-1]. If s >= X, every bit equals a[W-1].
- ROL: out = {W zeros, a rotated left by (s mod W)}.
- Shift is decomposed into log2(X)+1 binary steps (the final step handles s >= X) distributed across STAGES registers. Each register holds a valid bit, partial data, op, the remaining shamt bits and the tag.
- Latency: a result appears exactly STAGES cycles after acceptance when out_ready stays high.
- Throughput: one operation per cycle.
- Flow control is per-stage bubble-collapsing:
  - A stage loads when it is empty or its content moves downstream in the same cycle.
  - The last stage drains when out_ready=1.
  - in_ready = first stage is empty, or the first stage advances this cycle.
- in_ready is combinational from out_ready and the stage valid bits. There is no combinational path from in_* to out_*.
- Holds under stall:
  - While out_valid && !out_ready, out_data, out_tag and out_sticky stay stable.
  - With the pipeline full and stalled, in_ready=0.
- Ordering: results leave in acceptance order; no loss, no duplication.
- Simultaneous accept and drain with a full pipeline: allowed; the occupancy count is unchanged.
- Reset values:
  - rst_n low clears all stage valid bits, data, tags and sticky registers immediately (asynchronous).
  - out_valid=0, out_data=0, out_tag=0, out_sticky=0.
  - in_ready=1 from the first clock edge after rst_n is released.
  - In-flight operations are discarded and never emitted.
- No illegal in_op encodings exist. in_shamt values outside 0..X-1 follow the rules above.

Optional Feature:
- Macro: SHIFT_STICKY_EN.
- When defined:
  - out_sticky is added.
  - For SRL and SRA it is the OR of all bits of {a, W zeros} shifted below bit 0. For s >= X it is the OR of all bits of a.
  - For SLL and ROL it is 0.
  - It is pipelined with the data and has identical latency and stall behaviour.
- When undefined: the port, the logic and the registers are absent. Data and timing behaviour are identical.

Test Plan:
- SLL, a=0x8000_0001, s=31 -> out_data=0x4000_0000_8000_0000, tag echoed, out_valid exactly 2 cycles after accept (W=32, STAGES=2).
- Right shifts with a=0x8000_0000, s=4:
  - SRA -> 0xF800_0000_0000_0000.
  - SRL -> 0x0800_0000_0000_0000.
- Range checks:
  - SLL a=1, s=63 -> 0x8000_0000_0000_0000.
  - SLL s=64 -> 0.
  - SRA a=0x8000_0000, s=100 -> 0xFFFF_FFFF_FFFF_FFFF.
- ROL and sticky:
  - ROL a=0x1234_5678, s=36 -> 0x0000_0000_2345_6781.
  - With SHIFT_STICKY_EN, SRL a=0x0000_000F, s=35 -> out_data=0x1, out_sticky=1.
- Backpressure: 6 back-to-back ops with tags 0..5, out_ready held low for cycles 3..7 -> in_ready drops once STAGES ops are held; all 6 results emerge in tag order 0..5, none lost or repeated; data stable while stalled.
- Reset mid-flight: 2 ops in flight, rst_n pulsed low between clock edges -> out_valid=0 and out_data=0 immediately; no result emitted after release; the next op accepted completes normally.
